alpha_recursion: RTL and testbench

Forward state-metric (alpha) unit for the max-log-MAP SISO decoder. It sits directly downstream of the branch-metric stage and consumes its `init_branch1_t`/`init_branch2_t`/`valid_out` stream. It runs the 8-state LTE constituent-code trellis forward over one block of `blklen` steps. After every accepted step it emits the normalized alpha vector for the backward/LLR stages.

---
 rtl/alpha_recursion.sv | 135 +++++++++++++
 tb/tb_alpha_recursion.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/alpha_recursion.sv
// alpha_recursion: forward state-metric unit of the max-log-MAP SISO decoder.
// Runs the 8-state LTE constituent trellis forward over one block and emits
// the normalized alpha vector one cycle after each accepted branch-metric step.
//
// state | meaning
// IDLE  | waiting for a non-zero block length; valid_in ignored
// RUN   | one trellis step per valid_in until step blklen-1 completes
module alpha_recursion #(
    parameter int BW       = 16,
    parameter int AW       = 16,
    parameter int NEG_INIT = -16384
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [15:0]     blklen,
    input  logic            valid_blklen,
    input  logic [BW-1:0]   init_branch1,
    input  logic [BW-1:0]   init_branch2,
    input  logic            valid_in,
    output logic [8*AW-1:0] alpha_out,
    output logic            valid_out,
    output logic            last_out,
    output logic            busy
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    // Datapath width: the recursion itself fits in max(AW,BW)+2 bits, the
    // extra bit keeps the normalizing subtraction from wrapping before the
    // saturation compare sees it.
    localparam int MW = (AW > BW) ? AW : BW;
    localparam int CW = MW + 3;

    localparam logic signed [AW-1:0] NEG_A  = NEG_INIT[AW-1:0];
    localparam logic signed [CW-1:0] SAT_HI = {{(CW-AW+1){1'b0}}, {(AW-1){1'b1}}};
    localparam logic signed [CW-1:0] SAT_LO = {{(CW-AW+1){1'b1}}, {(AW-1){1'b0}}};

    logic [0:0]             state;
    logic [15:0]            len;
    logic [15:0]            k;
    logic signed [AW-1:0]   alpha [8];
    logic signed [CW-1:0]   alpha_x [8];
    logic signed [CW-1:0]   best [8];
    logic signed [AW-1:0]   nrm [8];
    logic [8*AW-1:0]        nrm_packed;
    logic signed [CW-1:0]   b1x;
    logic signed [CW-1:0]   b2x;

    assign b1x  = {{(CW-BW){init_branch1[BW-1]}}, init_branch1};
    assign b2x  = {{(CW-BW){init_branch2[BW-1]}}, init_branch2};
    assign busy = (state == RUN);

    // Next state ns = {a, s1, s2}, so its two predecessors are {ns[1], ns[0], s3}
    // for s3 = 0/1; u and p for each follow from a = ns[2].
    for (genvar ns = 0; ns < 8; ns++) begin : g_acs
        localparam int S0 = (ns % 4) * 2;
        localparam int S1 = S0 + 1;
        localparam bit U0 = bit'(((ns >> 2) ^ ns) & 1);
        localparam bit P0 = bit'(((ns >> 2) ^ (ns >> 1)) & 1);

        logic signed [CW-1:0] g0;
        logic signed [CW-1:0] g1;
        logic signed [CW-1:0] c0;
        logic signed [CW-1:0] c1;
        logic signed [CW-1:0] diff;

        assign alpha_x[ns] = {{(CW-AW){alpha[ns][AW-1]}}, alpha[ns]};

        // Add-compare-select for this next state, then normalize against state 0.
        always_comb begin
            g0   = (U0 ? b1x : '0) + (P0 ? b2x : '0);
            g1   = (U0 ? '0 : b1x) + (P0 ? '0 : b2x);
            c0   = alpha_x[S0] + g0;
            c1   = alpha_x[S1] + g1;
            best[ns] = (c0 >= c1) ? c0 : c1;
            diff = best[ns] - best[0];
            if (diff > SAT_HI) begin
                nrm[ns] = SAT_HI[AW-1:0];
            end else if (diff < SAT_LO) begin
                nrm[ns] = SAT_LO[AW-1:0];
            end else begin
                nrm[ns] = diff[AW-1:0];
            end
        end

        assign nrm_packed[ns*AW +: AW] = nrm[ns];
    end

    // Block sequencing, metric registers and the registered output strobe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            len       <= '0;
            k         <= '0;
            alpha_out <= '0;
            valid_out <= 1'b0;
            last_out  <= 1'b0;
            for (int s = 0; s < 8; s++) begin
                alpha[s] <= (s == 0) ? '0 : NEG_A;
            end
        end else begin
            valid_out <= 1'b0;
            last_out  <= 1'b0;
            case (state)
                IDLE: begin
                    if (valid_blklen && (blklen != 16'd0)) begin
                        state <= RUN;
                        len   <= blklen;
                        k     <= '0;
                        for (int s = 0; s < 8; s++) begin
                            alpha[s] <= (s == 0) ? '0 : NEG_A;
                        end
                    end
                end
                RUN: begin
                    if (valid_in) begin
                        for (int s = 0; s < 8; s++) begin
                            alpha[s] <= nrm[s];
                        end
                        alpha_out <= nrm_packed;
                        valid_out <= 1'b1;
                        k         <= k + 16'd1;
                        if (k == len - 16'd1) begin
                            last_out <= 1'b1;
                            state    <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alpha_recursion.sv
// Directed bench for alpha_recursion with a cycle-level reference model.
module tb_alpha_recursion;

    logic         clk = 1'b0;
    logic         rst;
    logic [15:0]  blklen;
    logic         valid_blklen;
    logic [15:0]  init_branch1;
    logic [15:0]  init_branch2;
    logic         valid_in;
    logic [127:0] alpha_out;
    logic         valid_out;
    logic         last_out;
    logic         busy;

    int n_tests = 0;
    int n_fail  = 0;

    int           m_alpha [8];
    bit           m_run;
    int           m_len;
    int           m_k;
    logic [127:0] e_out;
    bit           e_valid;
    bit           e_last;
    int           n_strobe;
    int           n_last;

    alpha_recursion #(.BW(16), .AW(16), .NEG_INIT(-16384)) dut (
        .clk          (clk),
        .rst          (rst),
        .blklen       (blklen),
        .valid_blklen (valid_blklen),
        .init_branch1 (init_branch1),
        .init_branch2 (init_branch2),
        .valid_in     (valid_in),
        .alpha_out    (alpha_out),
        .valid_out    (valid_out),
        .last_out     (last_out),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_init();
        m_alpha[0] = 0;
        for (int s = 1; s < 8; s++) m_alpha[s] = -16384;
    endtask

    // Forward trellis walk straight from the encoder equations.
    task automatic model_step(input int b1, input int b2);
        int best [8];
        bit has [8];
        int v;
        for (int s = 0; s < 8; s++) has[s] = 1'b0;
        for (int s = 0; s < 8; s++) begin
            for (int u = 0; u < 2; u++) begin
                int s1, s2, s3, a, p, ns, c;
                s1 = (s >> 2) & 1;
                s2 = (s >> 1) & 1;
                s3 = s & 1;
                a  = u ^ s2 ^ s3;
                p  = a ^ s1 ^ s3;
                ns = 4 * a + 2 * s1 + s2;
                c  = m_alpha[s] + (u != 0 ? b1 : 0) + (p != 0 ? b2 : 0);
                if (!has[ns] || c > best[ns]) begin
                    best[ns] = c;
                    has[ns]  = 1'b1;
                end
            end
        end
        for (int s = 0; s < 8; s++) begin
            v = best[s] - best[0];
            if (v > 32767)  v = 32767;
            if (v < -32768) v = -32768;
            m_alpha[s] = v;
            e_out[s*16 +: 16] = v[15:0];
        end
    endtask

    // Drive one cycle of inputs (called at a falling edge), advance the model,
    // then check every output at the next falling edge.
    task automatic cyc(input bit vi, input int b1, input int b2, input bit vb, input int bl);
        valid_in     = vi;
        init_branch1 = b1[15:0];
        init_branch2 = b2[15:0];
        valid_blklen = vb;
        blklen       = bl[15:0];
        e_valid = 1'b0;
        e_last  = 1'b0;
        if (m_run) begin
            if (vi) begin
                model_step(b1, b2);
                e_valid = 1'b1;
                e_last  = (m_k == m_len - 1);
                m_k++;
                if (e_last) m_run = 1'b0;
            end
        end else if (vb && bl != 0) begin
            m_run = 1'b1;
            m_len = bl;
            m_k   = 0;
            model_init();
        end
        @(negedge clk);
        check_val("valid_out", valid_out, e_valid);
        check_val("last_out", last_out, e_last);
        check_val("busy", busy, m_run);
        check_val("alpha_out", alpha_out, e_out);
        if (valid_out) n_strobe++;
        if (last_out)  n_last++;
    endtask

    function automatic int rnd(input int mag);
        return int'($urandom_range(0, 2 * mag)) - mag;
    endfunction

    initial begin
        rst = 1'b0;
        blklen = '0; valid_blklen = 1'b0;
        init_branch1 = '0; init_branch2 = '0; valid_in = 1'b0;
        m_run = 1'b0; m_len = 0; m_k = 0; e_out = '0;
        n_strobe = 0; n_last = 0;
        model_init();

        repeat (2) @(negedge clk);
        check_val("rst_alpha", alpha_out, 128'h0);
        check_val("rst_valid", valid_out, 1'b0);
        check_val("rst_last", last_out, 1'b0);
        check_val("rst_busy", busy, 1'b0);
        rst = 1'b1;
        @(negedge clk);

        // valid_in in IDLE and a zero length are both ignored
        repeat (3) cyc(1'b1, 100, -50, 1'b0, 0);
        cyc(1'b0, 0, 0, 1'b1, 0);
        cyc(1'b1, 7, 7, 1'b0, 0);
        check_val("idle_strobes", 32'(n_strobe), 32'd0);

        // blklen=1; valid_in coincident with the load is dropped
        cyc(1'b1, 10, 4, 1'b1, 1);
        check_val("load_no_out", valid_out, 1'b0);
        cyc(1'b1, 10, 4, 1'b0, 0);
        check_val("b1_alpha0", alpha_out[0 +: 16], 16'h0000);
        check_val("b1_alpha4", alpha_out[64 +: 16], 16'd14);
        check_val("b1_alpha1", alpha_out[16 +: 16], 16'hC00A);
        check_val("b1_last", last_out, 1'b1);
        check_val("b1_busy", busy, 1'b0);
        cyc(1'b1, 3, 3, 1'b0, 0);
        cyc(1'b1, 5, 9, 1'b0, 0);

        // 512 zero-metric steps with 1..3 idle cycles between them
        n_strobe = 0; n_last = 0;
        cyc(1'b0, 0, 0, 1'b1, 512);
        for (int i = 0; i < 512; i++) begin
            cyc(1'b1, 0, 0, 1'b0, 0);
            if (i >= 2) check_val("zero_steady", alpha_out, 128'h0);
            repeat ($urandom_range(1, 3)) cyc(1'b0, 0, 0, 1'b0, 0);
        end
        check_val("zero_strobes", 32'(n_strobe), 32'd512);
        check_val("zero_lasts", 32'(n_last), 32'd1);

        // full-range metrics: saturation, never wrap
        cyc(1'b0, 0, 0, 1'b1, 200);
        for (int i = 0; i < 200; i++) begin
            cyc(1'b1, rnd(32767), rnd(32767), 1'b0, 0);
            check_val("sat_alpha0", alpha_out[0 +: 16], 16'h0000);
        end

        // valid_blklen=700 mid-block is ignored
        n_strobe = 0; n_last = 0;
        cyc(1'b0, 0, 0, 1'b1, 512);
        for (int i = 0; i < 512; i++) begin
            cyc(1'b1, rnd(300), rnd(300), (i == 200), (i == 200) ? 700 : 0);
        end
        check_val("mid_strobes", 32'(n_strobe), 32'd512);
        check_val("mid_lasts", 32'(n_last), 32'd1);

        // reset at step 100 abandons the block immediately
        cyc(1'b0, 0, 0, 1'b1, 512);
        for (int i = 0; i < 100; i++) cyc(1'b1, rnd(1000), rnd(1000), 1'b0, 0);
        valid_in = 1'b0;
        #2 rst = 1'b0;
        #1;
        check_val("mrst_alpha", alpha_out, 128'h0);
        check_val("mrst_valid", valid_out, 1'b0);
        check_val("mrst_busy", busy, 1'b0);
        m_run = 1'b0; e_out = '0; model_init();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // fresh 40-step block, then a back-to-back block loaded in the last_out cycle
        n_strobe = 0; n_last = 0;
        cyc(1'b0, 0, 0, 1'b1, 40);
        for (int i = 0; i < 40; i++) cyc(1'b1, rnd(2000), rnd(2000), 1'b0, 0);
        check_val("b2b_last1", last_out, 1'b1);
        cyc(1'b0, 0, 0, 1'b1, 40);
        cyc(1'b1, 10, 4, 1'b0, 0);
        check_val("b2b_alpha4", alpha_out[64 +: 16], 16'd14);
        check_val("b2b_alpha1", alpha_out[16 +: 16], 16'hC00A);
        for (int i = 1; i < 40; i++) cyc(1'b1, rnd(2000), rnd(2000), 1'b0, 0);
        check_val("b2b_strobes", 32'(n_strobe), 32'd80);
        check_val("b2b_lasts", 32'(n_last), 32'd2);
        cyc(1'b1, 1, 1, 1'b0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
